sa_cache_ctrl: RTL and testbench

Parametrised N-way set-associative cache controller with true-LRU replacement, a write-through/write-allocate policy, and valid/ready-style handshakes on both the CPU side and the memory side. It is the next generation of the team's four-way cache, comparator and mux datapath. It sits between the processor request port and the word-addressed RAM model. Tag, data, valid and age state are held internally. Misses and writes are serviced through a single outstanding memory transaction.

---
 rtl/sa_cache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_sa_cache_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: N-way set-associative cache controller, true-LRU replacement,
// write-through / write-allocate, one outstanding memory transaction.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          processor request (accepted while cpu_ready)
//   cpu_ready/done/rdata/hit       processor response (done is a one-cycle pulse)
//   mem_req/we/addr/wdata          memory request, held until mem_ack
//   mem_ack/rdata                  memory acknowledge with same-cycle read data
//   hit_cnt, miss_cnt              saturating statistics counters
module sa_cache_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int unsigned SETS  = 1 << IDX_W;
    localparam int unsigned AGE_W = $clog2(WAYS);
    localparam int unsigned WAY_W = AGE_W;
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_LOOKUP = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4
    } state_t;

    typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

    // Per-set storage; only the valid bits and ages need clearing, done by INIT.
    logic [WAYS-1:0]             valid_mem [SETS];
    age_vec_t                    age_mem   [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [SETS];
    logic [WAYS-1:0][DATA_W-1:0] data_mem  [SETS];

    state_t              state, state_n;
    logic [IDX_W-1:0]    init_idx, init_idx_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                we_q, we_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic                hit_q, hit_n;

    logic                cpu_ready_n, cpu_done_n, cpu_hit_n;
    logic [DATA_W-1:0]   cpu_rdata_n;
    logic                mem_req_n, mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [CNT_W-1:0]    hit_cnt_n, miss_cnt_n;

    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [WAYS-1:0]             cur_valid;
    age_vec_t                    cur_ages;
    logic [WAYS-1:0][TAG_W-1:0]  cur_tags;
    logic [WAYS-1:0][DATA_W-1:0] cur_data;

    logic                hit_any, inv_any;
    logic [WAY_W-1:0]    hit_way, inv_way, lru_way, victim_way, sel_way;

    logic                meta_we;
    logic [IDX_W-1:0]    meta_idx;
    logic [WAYS-1:0]     meta_valid;
    age_vec_t            meta_age;
    logic                line_we;
    logic [WAY_W-1:0]    line_way;
    logic [DATA_W-1:0]   line_data;

    assign idx_q     = addr_q[IDX_W+1:2];
    assign tag_q     = addr_q[ADDR_W-1:IDX_W+2];
    assign cur_valid = valid_mem[idx_q];
    assign cur_ages  = age_mem[idx_q];
    assign cur_tags  = tag_mem[idx_q];
    assign cur_data  = data_mem[idx_q];

    // Move way w to most-recent: younger-than-w ways age by one, w becomes 0.
    function automatic age_vec_t touch(input age_vec_t ages, input logic [WAY_W-1:0] w);
        age_vec_t res;
        for (int i = 0; i < int'(WAYS); i++) begin
            res[i] = (ages[i] < ages[w]) ? ages[i] + 1'b1 : ages[i];
        end
        res[w] = '0;
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Tag compare and victim choice; descending loops make the lowest index win.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (cur_valid[i] && (cur_tags[i] == tag_q)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!cur_valid[i]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(i);
            end
            if (cur_ages[i] == AGE_W'(WAYS - 1)) begin
                lru_way = WAY_W'(i);
            end
        end
        victim_way = inv_any ? inv_way : lru_way;
        sel_way    = hit_any ? hit_way : victim_way;
    end

    // Next-state, next-output and storage-write decode.
    always_comb begin
        state_n     = state;
        init_idx_n  = init_idx;
        addr_n      = addr_q;
        we_n        = we_q;
        wdata_n     = wdata_q;
        hit_n       = hit_q;
        cpu_done_n  = 1'b0;
        cpu_rdata_n = cpu_rdata;
        cpu_hit_n   = cpu_hit;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        hit_cnt_n   = hit_cnt;
        miss_cnt_n  = miss_cnt;
        meta_we     = 1'b0;
        meta_idx    = idx_q;
        meta_valid  = cur_valid;
        meta_age    = cur_ages;
        line_we     = 1'b0;
        line_way    = victim_way;
        line_data   = wdata_q;

        unique case (state)
            S_INIT: begin
                meta_we    = 1'b1;
                meta_idx   = init_idx;
                meta_valid = '0;
                for (int i = 0; i < int'(WAYS); i++) begin
                    meta_age[i] = AGE_W'(i);
                end
                init_idx_n = init_idx + 1'b1;
                if (init_idx == IDX_W'(SETS - 1)) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_req) begin
                    addr_n  = cpu_addr;
                    we_n    = cpu_we;
                    wdata_n = cpu_wdata;
                    state_n = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!we_q && hit_any) begin
                    cpu_rdata_n = cur_data[hit_way];
                    cpu_hit_n   = 1'b1;
                    cpu_done_n  = 1'b1;
                    meta_we     = 1'b1;
                    meta_age    = touch(cur_ages, hit_way);
                    hit_cnt_n   = sat_inc(hit_cnt);
                    state_n     = S_IDLE;
                end else if (!we_q) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = addr_q;
                    miss_cnt_n  = sat_inc(miss_cnt);
                    state_n     = S_MEM_RD;
                end else begin
                    // Write allocates immediately; memory write-through follows.
                    line_we              = 1'b1;
                    line_way             = sel_way;
                    line_data            = wdata_q;
                    meta_we              = 1'b1;
                    meta_valid[sel_way]  = 1'b1;
                    meta_age             = touch(cur_ages, sel_way);
                    hit_n                = hit_any;
                    if (hit_any) begin
                        hit_cnt_n  = sat_inc(hit_cnt);
                    end else begin
                        miss_cnt_n = sat_inc(miss_cnt);
                    end
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = addr_q;
                    mem_wdata_n = wdata_q;
                    state_n     = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    line_we                = 1'b1;
                    line_way               = victim_way;
                    line_data              = mem_rdata;
                    meta_we                = 1'b1;
                    meta_valid[victim_way] = 1'b1;
                    meta_age               = touch(cur_ages, victim_way);
                    cpu_rdata_n            = mem_rdata;
                    cpu_hit_n              = 1'b0;
                    cpu_done_n             = 1'b1;
                    mem_req_n              = 1'b0;
                    state_n                = S_IDLE;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    cpu_hit_n  = hit_q;
                    cpu_done_n = 1'b1;
                    mem_req_n  = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase

        cpu_ready_n = (state_n == S_IDLE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_idx  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_n;
            init_idx  <= init_idx_n;
            addr_q    <= addr_n;
            we_q      <= we_n;
            wdata_q   <= wdata_n;
            hit_q     <= hit_n;
            cpu_ready <= cpu_ready_n;
            cpu_done  <= cpu_done_n;
            cpu_rdata <= cpu_rdata_n;
            cpu_hit   <= cpu_hit_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            hit_cnt   <= hit_cnt_n;
            miss_cnt  <= miss_cnt_n;
        end
    end

    // Cache arrays; contents are meaningless until INIT has swept the valid bits.
    always_ff @(posedge clk) begin
        if (meta_we) begin
            valid_mem[meta_idx] <= meta_valid;
            age_mem[meta_idx]   <= meta_age;
        end
        if (line_we) begin
            tag_mem[idx_q][line_way]  <= tag_q;
            data_mem[idx_q][line_way] <= line_data;
        end
    end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: directed bench for sa_cache_ctrl with a recency-list cache
// model, a word memory responder and a per-cycle output checker. A second
// instance with 2-bit counters runs the same traffic to exercise saturation.
module tb_sa_cache_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 1 << IDX_W;
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic              cpu_ready, cpu_done, cpu_hit, mem_req, mem_we;
    logic [DATA_W-1:0] cpu_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       hit_cnt, miss_cnt;

    logic              cpu_ready2, cpu_done2, cpu_hit2, mem_req2, mem_we2;
    logic [DATA_W-1:0] cpu_rdata2, mem_wdata2;
    logic [ADDR_W-1:0] mem_addr2;
    logic [1:0]        hit_cnt2, miss_cnt2;

    sa_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    sa_cache_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready2), .cpu_done(cpu_done2), .cpu_rdata(cpu_rdata2), .cpu_hit(cpu_hit2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic              m_valid [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [DATA_W-1:0] m_data  [SETS][WAYS];
    int                m_order [SETS][WAYS];   // way numbers, most recent first
    int                m_hits, m_miss, m_last_way;
    logic [DATA_W-1:0] ram [int unsigned];

    function automatic logic [DATA_W-1:0] ram_rd(input logic [ADDR_W-1:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int sat(input int n, input int bits);
        int mx = (1 << bits) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_init();
        for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < int'(WAYS); i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    task automatic model_access(input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata,
                                output bit hit, output logic [DATA_W-1:0] rdata);
        int s;
        int w;
        logic [TAG_W-1:0] t;
        s = int'(addr[IDX_W+1:2]);
        t = addr[ADDR_W-1:IDX_W+2];
        w = -1;
        for (int i = 0; i < int'(WAYS); i++)
            if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
        hit = (w >= 0);
        if (!hit) begin
            for (int i = 0; i < int'(WAYS); i++) if (w < 0 && !m_valid[s][i]) w = i;
            if (w < 0) w = m_order[s][WAYS-1];
        end
        rdata = '0;
        if (we) m_data[s][w] = wdata;
        else if (hit) rdata = m_data[s][w];
        else begin
            rdata = ram_rd(addr);
            m_data[s][w] = rdata;
        end
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = t;
        model_touch(s, w);
        if (hit) m_hits++; else m_miss++;
        m_last_way = w;
    endtask

    // ---------------- expectation / observation state ----------------
    bit                busy = 1'b0;
    bit                in_init = 1'b1;
    int                acc_cyc = 0;
    int                ack_stage = -1;
    bit                e_we, e_hit, e_mem;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rdata;
    int                e_hc_pre, e_mc_pre;

    int                o_done_stage, o_req_cycles;
    bit                o_hit, o_mem_we;
    logic [DATA_W-1:0] o_rdata, o_mem_wdata;
    logic [ADDR_W-1:0] o_mem_addr;

    // ---------------- memory responder ----------------
    int ack_dly = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (rst_n && mem_req) begin
            if (wcnt == ack_dly) begin
                mem_ack   = 1'b1;
                mem_rdata = ram_rd(mem_addr);
                if (mem_we) ram[mem_addr] = mem_wdata;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- per-cycle checker ----------------
    int c_stage;
    bit x_done, x_req, x_ready;
    int x_hc, x_mc;
    always @(negedge clk) begin
        if (rst_n) begin
            c_stage = busy ? (cyc - acc_cyc) : -1;
            x_done  = busy && (e_mem ? (ack_stage >= 0 && c_stage == ack_stage + 1) : (c_stage == 1));
            x_req   = busy && e_mem && c_stage >= 1 && (ack_stage < 0 || c_stage <= ack_stage);
            x_ready = !busy || x_done;
            x_hc    = (busy && c_stage == 0) ? e_hc_pre : m_hits;
            x_mc    = (busy && c_stage == 0) ? e_mc_pre : m_miss;
            if (x_req && mem_ack && ack_stage < 0) ack_stage = c_stage;

            chk("cpu_done", cpu_done, x_done);
            chk("cpu_done2", cpu_done2, x_done);
            chk("mem_req", mem_req, x_req);
            chk("mem_req2", mem_req2, x_req);
            if (!in_init) begin
                chk("cpu_ready", cpu_ready, x_ready);
                chk("cpu_ready2", cpu_ready2, x_ready);
            end
            chk("hit_cnt", hit_cnt, x_hc);
            chk("miss_cnt", miss_cnt, x_mc);
            chk("hit_cnt2", hit_cnt2, sat(x_hc, 2));
            chk("miss_cnt2", miss_cnt2, sat(x_mc, 2));

            if (busy && mem_req) begin
                o_req_cycles++;
                o_mem_we    = mem_we;
                o_mem_addr  = mem_addr;
                o_mem_wdata = mem_wdata;
            end
            if (x_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_addr2", mem_addr2, e_addr);
                chk("mem_we2", mem_we2, e_we);
                if (e_we) begin
                    chk("mem_wdata", mem_wdata, e_wdata);
                    chk("mem_wdata2", mem_wdata2, e_wdata);
                end
            end
            if (x_done) begin
                chk("cpu_hit", cpu_hit, e_hit);
                chk("cpu_hit2", cpu_hit2, e_hit);
                if (!e_we) begin
                    chk("cpu_rdata", cpu_rdata, e_rdata);
                    chk("cpu_rdata2", cpu_rdata2, e_rdata);
                end
                o_hit        = cpu_hit;
                o_rdata      = cpu_rdata;
                o_done_stage = c_stage;
                busy         = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout got busy after %0d cycles expected done", n);
            busy = 1'b0;
        end
    endtask

    task automatic txn_start(input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input int dly);
        bit h;
        logic [DATA_W-1:0] rd;
        wait_idle();
        ack_dly   = dly;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        e_hc_pre = m_hits;
        e_mc_pre = m_miss;
        model_access(we, addr, wdata, h, rd);
        e_we = we; e_addr = addr; e_wdata = wdata;
        e_hit = h; e_rdata = rd; e_mem = we || !h;
        acc_cyc = cyc;
        ack_stage = -1;
        o_req_cycles = 0;
        o_mem_we = 1'b0;
        o_mem_addr = '0;
        o_mem_wdata = '0;
        o_done_stage = -1;
        busy = 1'b1;
        cpu_req = 1'b0;
    endtask

    task automatic txn(input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int dly);
        txn_start(we, addr, wdata, dly);
        wait_idle();
    endtask

    task automatic do_reset();
        int n = 0;
        rst_n   = 1'b0;
        busy    = 1'b0;
        in_init = 1'b1;
        cpu_req = 1'b0;
        model_init();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        while (!cpu_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", n, 256);
        @(negedge clk);
        #1;
        in_init = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_init();
        do_reset();

        // write miss, then read hit of the same word
        txn(1'b1, 32'd20, 32'd10, 3);
        chk("wr_mem_we", o_mem_we, 1);
        chk("wr_mem_addr", o_mem_addr, 20);
        chk("wr_mem_wdata", o_mem_wdata, 10);
        chk("wr_req_cycles", o_req_cycles, 4);
        chk("wr_done_stage", o_done_stage, 5);
        chk("wr_hit", o_hit, 0);
        txn(1'b0, 32'd20, 32'd0, 0);
        chk("rd_hit_data", o_rdata, 10);
        chk("rd_hit_flag", o_hit, 1);
        chk("rd_hit_latency", o_done_stage, 1);
        chk("rd_hit_no_mem", o_req_cycles, 0);
        chk("rd_hit_cnt", hit_cnt, 1);
        chk("rd_miss_cnt", miss_cnt, 1);

        // write hit updates the line and memory
        txn(1'b1, 32'd20, 32'd77, 1);
        chk("wrhit_hit", o_hit, 1);
        txn(1'b0, 32'd20, 32'd0, 0);
        chk("wrhit_rd", o_rdata, 77);

        // read miss fill and re-read
        ram[32'h400] = 32'd500;
        txn(1'b0, 32'h400, 32'd0, 2);
        chk("fill_mem_we", o_mem_we, 0);
        chk("fill_mem_addr", o_mem_addr, 32'h400);
        chk("fill_rdata", o_rdata, 500);
        chk("fill_hit", o_hit, 0);
        txn(1'b0, 32'h400, 32'd0, 0);
        chk("refill_hit", o_hit, 1);
        chk("refill_rdata", o_rdata, 500);

        // LRU replacement in set 0 from a clean cache
        do_reset();
        txn(1'b0, 32'h000, 32'd0, 1);
        txn(1'b0, 32'h400, 32'd0, 0);
        txn(1'b0, 32'h800, 32'd0, 1);
        txn(1'b0, 32'hC00, 32'd0, 2);
        chk("lru_fill_way3", m_last_way, 3);
        txn(1'b0, 32'h000, 32'd0, 0);
        chk("lru_hit0", o_hit, 1);
        txn(1'b0, 32'h1000, 32'd0, 1);
        chk("lru_miss1000", o_hit, 0);
        chk("lru_victim_way", m_last_way, 1);
        txn(1'b0, 32'h400, 32'd0, 1);
        chk("lru_miss400", o_hit, 0);
        txn(1'b0, 32'h000, 32'd0, 0);
        chk("lru_hit0b", o_hit, 1);
        txn(1'b0, 32'h800, 32'd0, 0);
        chk("lru_miss800", o_hit, 0);

        // reset while a read miss waits on memory
        txn_start(1'b0, 32'h2000, 32'd0, 50);
        begin
            int n = 0;
            while (!mem_req && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("mid_mem_req_up", mem_req, 1);
        @(posedge clk);
        #2;
        do_reset();
        txn(1'b0, 32'd20, 32'd0, 0);
        chk("post_rst_miss", o_hit, 0);
        chk("post_rst_rdata", o_rdata, 77);

        // counter saturation on the 2-bit instance
        repeat (5) txn(1'b0, 32'd20, 32'd0, 0);
        chk("sat_hit_cnt16", hit_cnt, 5);
        chk("sat_hit_cnt2", hit_cnt2, 3);
        chk("sat_miss_cnt2", miss_cnt2, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
